// File: rtl/wb_irqctrl.sv
// Wishbone-slave interrupt controller: latches up to 32 sources into PENDING, masks them
// and drives irq_o plus a lowest-index-first VECTOR. Define IRQCTRL_SYNC_EN to add a 2-flop input synchronizer.
module wb_irqctrl #(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wb_stb_i,
    input  logic               wb_cyc_i,
    output logic               wb_ack_o,
    input  logic               wb_we_i,
    input  logic [31:0]        wb_adr_i,
    input  logic [3:0]         wb_sel_i,
    input  logic [31:0]        wb_dat_i,
    output logic [31:0]        wb_dat_o,
    input  logic [NUM_SRC-1:0] intr_i,
    output logic               irq_o
);

    localparam logic [7:0] ADR_PENDING = 8'h00;
    localparam logic [7:0] ADR_MASK    = 8'h04;
    localparam logic [7:0] ADR_MODE    = 8'h08;
    localparam logic [7:0] ADR_VECTOR  = 8'h0C;
    localparam logic [7:0] ADR_RAW     = 8'h10;

    logic [NUM_SRC-1:0] src;
    logic [NUM_SRC-1:0] src_d;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] mask;
    logic [NUM_SRC-1:0] mode;
    logic [NUM_SRC-1:0] edge_det;
    logic [NUM_SRC-1:0] set_v;
    logic [NUM_SRC-1:0] clr_v;
    logic [NUM_SRC-1:0] act;
    logic               ack;
    logic               acc;
    logic               wr;
    logic [4:0]         idx;
    logic [31:0]        vector;
    logic [31:0]        rd_data;
    logic               unused_bits;

    // Byte selects and upper address bits carry no meaning for a full-word register file.
    assign unused_bits = ^{wb_sel_i, wb_adr_i[31:8], wb_dat_i};

`ifdef IRQCTRL_SYNC_EN
    logic [NUM_SRC-1:0] sync_q1;
    logic [NUM_SRC-1:0] sync_q2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= intr_i;
            sync_q2 <= sync_q1;
        end
    end

    assign src = sync_q2;
`else
    assign src = intr_i;
`endif

    // An access is taken only while ack is low, so each stb&cyc phase gets exactly one ack.
    assign acc      = wb_stb_i & wb_cyc_i & ~ack;
    assign wr       = acc & wb_we_i;
    assign wb_ack_o = wb_stb_i & wb_cyc_i & ack;

    assign edge_det = src & ~src_d;
    assign set_v    = (mode & edge_det) | (~mode & src);
    assign clr_v    = (wr && wb_adr_i[7:0] == ADR_PENDING) ? wb_dat_i[NUM_SRC-1:0] : '0;
    assign act      = pending & mask;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (act[i]) idx = 5'(i);
        end
    end

    assign vector = (|act) ? {1'b1, 26'b0, idx} : 32'h0;

    always_comb begin
        rd_data = '0;
        case (wb_adr_i[7:0])
            ADR_PENDING: rd_data = 32'(pending);
            ADR_MASK:    rd_data = 32'(mask);
            ADR_MODE:    rd_data = 32'(mode);
            ADR_VECTOR:  rd_data = vector;
            ADR_RAW:     rd_data = 32'(src);
            default:     rd_data = '0;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack      <= 1'b0;
            wb_dat_o <= '0;
            irq_o    <= 1'b0;
            pending  <= '0;
            mask     <= '0;
            mode     <= '1;
            src_d    <= '0;
        end else begin
            ack     <= acc;
            src_d   <= src;
            // Set has priority over a same-cycle write-1-to-clear.
            pending <= set_v | (pending & ~clr_v);
            irq_o   <= |act;
            if (acc) wb_dat_o <= rd_data;
            if (wr && wb_adr_i[7:0] == ADR_MASK) mask <= wb_dat_i[NUM_SRC-1:0];
            if (wr && wb_adr_i[7:0] == ADR_MODE) mode <= wb_dat_i[NUM_SRC-1:0];
        end
    end

endmodule

// File: tb/tb_wb_irqctrl.sv
// Scoreboard bench for wb_irqctrl: directed scenarios plus random traffic, checked against
// a word-level reference model of the pending/mask/mode rules.
module tb_wb_irqctrl;

    localparam int          NUM_SRC  = 8;
    localparam logic [31:0] SRC_MASK = 32'h0000_00FF;

    logic               clk = 1'b0;
    logic               reset;
    logic               wb_stb;
    logic               wb_cyc;
    logic               wb_ack;
    logic               wb_we;
    logic [31:0]        wb_adr;
    logic [3:0]         wb_sel;
    logic [31:0]        wb_wdat;
    logic [31:0]        wb_rdat;
    logic [NUM_SRC-1:0] intr;
    logic               irq;

    wb_irqctrl #(.NUM_SRC(NUM_SRC)) dut (
        .clk      (clk),
        .reset    (reset),
        .wb_stb_i (wb_stb),
        .wb_cyc_i (wb_cyc),
        .wb_ack_o (wb_ack),
        .wb_we_i  (wb_we),
        .wb_adr_i (wb_adr),
        .wb_sel_i (wb_sel),
        .wb_dat_i (wb_wdat),
        .wb_dat_o (wb_rdat),
        .intr_i   (intr),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_read;
        logic [31:0] exp;
        string       name;
    } sb_t;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  adr;
        logic [31:0] dat;
    } wr_t;

    sb_t         sb_q[$];
    wr_t         wr_q[$];
    int          n_pass  = 0;
    int          n_total = 0;
    int unsigned cyc     = 0;

    logic [31:0] m_pend;
    logic [31:0] m_mask;
    logic [31:0] m_mode;
    logic [31:0] m_prev;
    logic        m_irq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] model_vector();
        logic [31:0] a;
        logic [31:0] low;
        a = m_pend & m_mask;
        if (a == 32'h0) return 32'h0;
        low = a & (~a + 32'd1);
        return {1'b1, 26'b0, 5'($clog2(low))};
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] adr);
        case (adr)
            8'h00:   return m_pend;
            8'h04:   return m_mask;
            8'h08:   return m_mode;
            8'h0C:   return model_vector();
            8'h10:   return 32'(intr);
            default: return 32'h0;
        endcase
    endfunction

    // Reference model: one step per clock of the pending/mask/mode rules.
    always @(posedge clk or negedge reset) begin : model
        logic [31:0] s;
        logic [31:0] setv;
        logic [31:0] clr;
        logic [31:0] nmask;
        logic [31:0] nmode;
        if (!reset) begin
            m_pend <= 32'h0;
            m_mask <= 32'h0;
            m_mode <= SRC_MASK;
            m_prev <= 32'h0;
            m_irq  <= 1'b0;
        end else begin
            s     = 32'(intr);
            setv  = (m_mode & s & ~m_prev) | (~m_mode & s);
            clr   = 32'h0;
            nmask = m_mask;
            nmode = m_mode;
            if (wr_q.size() > 0 && wr_q[0].cyc == cyc) begin
                case (wr_q[0].adr)
                    8'h00:   clr   = wr_q[0].dat;
                    8'h04:   nmask = wr_q[0].dat & SRC_MASK;
                    8'h08:   nmode = wr_q[0].dat & SRC_MASK;
                    default: ;
                endcase
                void'(wr_q.pop_front());
            end
            m_irq  <= |(m_pend & m_mask);
            m_pend <= (setv | (m_pend & ~clr)) & SRC_MASK;
            m_mask <= nmask;
            m_mode <= nmode;
            m_prev <= s;
            cyc    <= cyc + 1;
        end
    end

    // Monitor: irq_o against the model every cycle; every ack pops one scoreboard entry.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            check("irq_o", 32'(irq), 32'(m_irq));
            if (wb_ack) begin
                if (sb_q.size() == 0) begin
                    n_total++;
                    $display("FAIL ack: got unexpected ack, want none");
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    if (e.is_read) check(e.name, wb_rdat, e.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the edge that drops ack.
    task automatic bus(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                       input logic [31:0] exp, input string name);
        sb_t e;
        wr_t w;
        bit  got;
        got       = 1'b0;
        e.is_read = !we;
        e.exp     = exp;
        e.name    = name;
        sb_q.push_back(e);
        if (we) begin
            w.cyc = cyc;
            w.adr = adr;
            w.dat = dat;
            wr_q.push_back(w);
        end
        wb_stb  = 1'b1;
        wb_cyc  = 1'b1;
        wb_we   = we;
        wb_adr  = {24'($urandom()), adr};
        wb_sel  = 4'($urandom());
        wb_wdat = dat;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = wb_ack;
        end
        if (!got) begin
            n_total++;
            $display("FAIL %s: got no ack, want ack within 20 cycles", name);
            void'(sb_q.pop_back());
        end
        tick();
        wb_stb = 1'b0;
        wb_cyc = 1'b0;
        wb_we  = 1'b0;
    endtask

    task automatic wr(input logic [7:0] adr, input logic [31:0] dat);
        bus(1'b1, adr, dat, 32'h0, "write");
    endtask

    task automatic rd(input logic [7:0] adr, input string name);
        bus(1'b0, adr, 32'h0, model_read(adr), name);
    endtask

    task automatic rd_exp(input logic [7:0] adr, input logic [31:0] exp, input string name);
        bus(1'b0, adr, 32'h0, exp, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sb_t e;
        bit  got;
        logic [7:0] radr;
        reset   = 1'b0;
        wb_stb  = 1'b0;
        wb_cyc  = 1'b0;
        wb_we   = 1'b0;
        wb_adr  = 32'h0;
        wb_sel  = 4'h0;
        wb_wdat = 32'h0;
        intr    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(wb_ack), 32'h0);
        check("rst_dat", wb_rdat, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        reset = 1'b1;
        tick();
        rd_exp(8'h00, 32'h0, "rst_pending");
        rd_exp(8'h04, 32'h0, "rst_mask");
        rd_exp(8'h08, 32'hFF, "rst_mode");
        rd_exp(8'h0C, 32'h0, "rst_vector");

        // Timer trigger path.
        wr(8'h04, 32'h01);
        intr = 8'h01;
        tick();
        intr = 8'h00;
        check("timer_irq_1cyc", 32'(irq), 32'h0);
        tick();
        check("timer_irq_2cyc", 32'(irq), 32'h1);
        rd_exp(8'h00, 32'h01, "timer_pending");
        rd_exp(8'h0C, 32'h8000_0000, "timer_vector");
        wr(8'h00, 32'h01);

        // Priority between two simultaneous sources.
        wr(8'h04, 32'hFF);
        intr = 8'h24;
        tick();
        intr = 8'h00;
        rd_exp(8'h0C, 32'h8000_0002, "prio_vec_2");
        wr(8'h00, 32'h04);
        rd_exp(8'h0C, 32'h8000_0005, "prio_vec_5");
        wr(8'h00, 32'h20);
        check("prio_irq_drop", 32'(irq), 32'h0);
        rd_exp(8'h0C, 32'h0, "prio_vec_none");

        // Level mode re-sets pending while the source stays high.
        wr(8'h08, 32'hFE);
        intr = 8'h01;
        tick();
        wr(8'h00, 32'h01);
        rd_exp(8'h00, 32'h01, "level_reset");
        intr = 8'h00;
        wr(8'h00, 32'h01);
        rd_exp(8'h00, 32'h00, "level_cleared");
        check("level_irq_low", 32'(irq), 32'h0);
        wr(8'h08, 32'hFF);

        // Edge arriving in the same cycle as its clear.
        intr = 8'h08;
        wr(8'h00, 32'h08);
        intr = 8'h00;
        rd_exp(8'h00, 32'h08, "collision_set_wins");
        wr(8'h00, 32'h08);

        // Masked source still latches.
        wr(8'h04, 32'h00);
        intr = 8'h02;
        tick();
        intr = 8'h00;
        tick();
        tick();
        check("masked_irq_low", 32'(irq), 32'h0);
        rd_exp(8'h00, 32'h02, "masked_pending");
        wr(8'h04, 32'h02);
        check("unmasked_irq_high", 32'(irq), 32'h1);

        // Reset asserted in the middle of a read.
        e.is_read = 1'b1;
        e.exp     = model_read(8'h00);
        e.name    = "pend_before_reset";
        sb_q.push_back(e);
        wb_stb = 1'b1;
        wb_cyc = 1'b1;
        wb_we  = 1'b0;
        wb_adr = 32'h0;
        got    = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = wb_ack;
        end
        if (!got) begin
            n_total++;
            $display("FAIL rst_mid_read: got no ack, want ack within 20 cycles");
            void'(sb_q.pop_back());
        end
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_ack", 32'(wb_ack), 32'h0);
        check("rst_mid_irq", 32'(irq), 32'h0);
        check("rst_mid_dat", wb_rdat, 32'h0);
        wb_stb = 1'b0;
        wb_cyc = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        rd_exp(8'h00, 32'h0, "pend_after_reset");
        rd_exp(8'h04, 32'h0, "mask_after_reset");
        rd_exp(8'h40, 32'h0, "unmapped_read");
        intr = 8'h5A;
        tick();
        rd_exp(8'h10, 32'h5A, "raw_read");
        intr = 8'h00;

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 6))
                0, 1: begin
                    intr = NUM_SRC'($urandom());
                    tick();
                end
                2: begin
                    case ($urandom_range(0, 4))
                        0:       radr = 8'h00;
                        1:       radr = 8'h04;
                        2:       radr = 8'h08;
                        3:       radr = 8'h40;
                        default: radr = 8'h00;
                    endcase
                    wr(radr, $urandom());
                end
                3, 4: begin
                    case ($urandom_range(0, 6))
                        0:       radr = 8'h00;
                        1:       radr = 8'h04;
                        2:       radr = 8'h08;
                        3:       radr = 8'h0C;
                        4:       radr = 8'h10;
                        5:       radr = 8'h14;
                        default: radr = 8'($urandom());
                    endcase
                    rd(radr, "rand_read");
                end
                default: repeat ($urandom_range(1, 3)) tick();
            endcase
        end

        repeat (4) tick();
        check("sb_drain", 32'(sb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
